// File: rtl/pipelined_adder.sv
// pipelined_adder: add/sub with the carry chain cut into SEGMENTS registered slices, valid/ready full-pipeline stall.
// Optional PIPELINED_ADDER_SATURATE_EN adds a SAT input that clamps signed overflow in the final stage.
module pipelined_adder #(
  parameter int OPERAND_BIT = 10,
  parameter int SEGMENTS = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic IN_VALID,
  output logic IN_READY,
  input  logic [OPERAND_BIT-1:0] A,
  input  logic [OPERAND_BIT-1:0] B,
  input  logic Cin,
  input  logic SUB,
  output logic OUT_VALID,
  input  logic OUT_READY,
  output logic [OPERAND_BIT-1:0] S,
  output logic Cout,
  output logic OVF
`ifdef PIPELINED_ADDER_SATURATE_EN
  ,
  input  logic SAT
`endif
);
  localparam int N = OPERAND_BIT;
  localparam int W = (N + SEGMENTS - 1) / SEGMENTS;
  localparam logic [N:0] ONE = 1;
  logic en, sat_in;
  assign en = !OUT_VALID || OUT_READY;
  assign IN_READY = en;
`ifdef PIPELINED_ADDER_SATURATE_EN
  assign sat_in = SAT;
`else
  assign sat_in = 1'b0;
`endif
  for (genvar k = 0; k < SEGMENTS; k++) begin : g_stage
    localparam int LO = k * W < N ? k * W : N;
    localparam int HI = (k + 1) * W < N ? (k + 1) * W : N;
    localparam logic [N:0] M = (ONE << HI) - (ONE << LO);
    localparam bit TOP = LO < N && HI == N;
    logic [N-1:0] a_i, b_i, s_i, s_r;
    logic c_i, v_i, t_i, o_i, x_i;
    logic c_r, v_r, t_r, o_r, x_r;
    logic [N:0] sum;
    if (k == 0) begin : g_head
      assign a_i = A;
      assign b_i = SUB ? ~B : B;
      assign s_i = '0;
      assign c_i = SUB ? ~Cin : Cin;
      assign v_i = IN_VALID;
      assign t_i = sat_in;
      assign o_i = 1'b0;
      assign x_i = 1'b0;
    end else begin : g_body
      assign a_i = g_stage[k-1].g_ops.a_r;
      assign b_i = g_stage[k-1].g_ops.b_r;
      assign s_i = g_stage[k-1].s_r;
      assign c_i = g_stage[k-1].c_r;
      assign v_i = g_stage[k-1].v_r;
      assign t_i = g_stage[k-1].t_r;
      assign o_i = g_stage[k-1].o_r;
      assign x_i = g_stage[k-1].x_r;
    end
    // Only bits [LO,HI) take part; bit HI of the masked sum is this slice's carry-out.
    assign sum = ({1'b0, a_i} & M) + ({1'b0, b_i} & M) + ({{N{1'b0}}, c_i} << LO);
    if (k < SEGMENTS - 1) begin : g_ops
      logic [N-1:0] a_r, b_r;
      always_ff @(posedge CLK)
        if (en) begin
          a_r <= a_i;
          b_r <= b_i;
        end
    end
    always_ff @(posedge CLK)
      if (RST) begin
        s_r <= '0;
        c_r <= 1'b0;
        v_r <= 1'b0;
        t_r <= 1'b0;
        o_r <= 1'b0;
        x_r <= 1'b0;
      end else if (en) begin
        s_r <= (s_i & ~M[N-1:0]) | (sum[N-1:0] & M[N-1:0]);
        c_r <= sum[HI];
        v_r <= v_i;
        t_r <= t_i;
        o_r <= TOP ? (a_i[N-1] == b_i[N-1]) && (sum[N-1] != a_i[N-1]) : o_i;
        x_r <= TOP ? a_i[N-1] : x_i;
      end
  end
  assign OUT_VALID = g_stage[SEGMENTS-1].v_r;
  assign Cout = g_stage[SEGMENTS-1].c_r;
  assign OVF = g_stage[SEGMENTS-1].o_r;
  assign S = g_stage[SEGMENTS-1].t_r && g_stage[SEGMENTS-1].o_r
           ? {g_stage[SEGMENTS-1].x_r, {(N-1){~g_stage[SEGMENTS-1].x_r}}}
           : g_stage[SEGMENTS-1].s_r;
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: scoreboard bench for pipelined_adder, 2-segment main instance plus 3- and 10-segment corner instances.
module tb_pipelined_adder;
  localparam int N = 10;
  localparam int SEG = 2;
  typedef struct packed { logic [N-1:0] s; logic c; logic o; } res_t;
  typedef struct { res_t r; int due; } cexp_t;
  logic CLK = 0, RST = 1, IN_VALID = 0, OUT_READY = 1, Cin = 0, SUB = 0, cv = 0;
  logic [N-1:0] A = '0, B = '0;
  logic IN_READY, OUT_VALID, Cout, OVF;
  logic [N-1:0] S;
  logic [1:0] c_vld, c_rdy, c_co, c_ov;
  logic [N-1:0] c_s [2];
`ifdef PIPELINED_ADDER_SATURATE_EN
  logic SAT = 0;
`endif
  int n_chk = 0, n_fail = 0, cyc = 0;
  res_t q[$];
  cexp_t cq0[$], cq1[$];

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  pipelined_adder #(.OPERAND_BIT(N), .SEGMENTS(SEG)) u_dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY), .A(A), .B(B), .Cin(Cin), .SUB(SUB),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .S(S), .Cout(Cout), .OVF(OVF)
`ifdef PIPELINED_ADDER_SATURATE_EN
    , .SAT(SAT)
`endif
  );
  pipelined_adder #(.OPERAND_BIT(N), .SEGMENTS(3)) u_seg3 (
    .CLK(CLK), .RST(RST), .IN_VALID(cv), .IN_READY(c_rdy[0]), .A(A), .B(B), .Cin(Cin), .SUB(SUB),
    .OUT_VALID(c_vld[0]), .OUT_READY(1'b1), .S(c_s[0]), .Cout(c_co[0]), .OVF(c_ov[0])
`ifdef PIPELINED_ADDER_SATURATE_EN
    , .SAT(SAT)
`endif
  );
  pipelined_adder #(.OPERAND_BIT(N), .SEGMENTS(N)) u_segn (
    .CLK(CLK), .RST(RST), .IN_VALID(cv), .IN_READY(c_rdy[1]), .A(A), .B(B), .Cin(Cin), .SUB(SUB),
    .OUT_VALID(c_vld[1]), .OUT_READY(1'b1), .S(c_s[1]), .Cout(c_co[1]), .OVF(c_ov[1])
`ifdef PIPELINED_ADDER_SATURATE_EN
    , .SAT(SAT)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic res_t mk(input logic [N-1:0] s, input logic c, input logic o);
    return {s, c, o};
  endfunction

  // Called at posedge+1; the expected result is queued just before the accepting edge.
  task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic ci, input logic sb, input res_t e);
    int n = 0;
    A = a; B = b; Cin = ci; SUB = sb; IN_VALID = 1;
    #2;
    while (!IN_READY && n < 50) begin
      @(posedge CLK); #3;
      n++;
    end
    chk("in_ready_wait", IN_READY, 1);
    q.push_back(e);
    @(posedge CLK); #1;
    IN_VALID = 0;
  endtask

  task automatic csend(input logic [N-1:0] a, input logic [N-1:0] b, input logic ci, input logic sb, input res_t e);
    A = a; B = b; Cin = ci; SUB = sb; cv = 1;
    chk("corner_in_ready", c_rdy, 2'b11);
    cq0.push_back('{e, cyc + 3});
    cq1.push_back('{e, cyc + N});
    @(posedge CLK); #1;
    cv = 0;
  endtask

  initial begin
    logic pv = 0, pr = 0, pst = 1;
    res_t hold = '0;
    forever begin
      @(negedge CLK);
      if (RST) q.delete();
      else begin
        if (pv && !pr && !pst) chk("stall_hold", {OUT_VALID, S, Cout, OVF}, {1'b1, hold});
        if (OUT_VALID && !OUT_READY) chk("stall_in_ready", IN_READY, 0);
        if (OUT_VALID && OUT_READY) begin
          if (q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_out: got %0h, expected no beat", {S, Cout, OVF});
          end else chk("result", {S, Cout, OVF}, q.pop_front());
        end
      end
      pv = OUT_VALID; pr = OUT_READY; pst = RST; hold = {S, Cout, OVF};
    end
  end

  initial begin
    cexp_t e;
    forever begin
      @(negedge CLK);
      if (c_vld[0]) begin
        if (cq0.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL seg3_unexpected: got %0h, expected no beat", c_s[0]);
        end else begin
          e = cq0.pop_front();
          chk("seg3_result", {c_s[0], c_co[0], c_ov[0]}, e.r);
          chk("seg3_latency", cyc, e.due);
        end
      end
      if (c_vld[1]) begin
        if (cq1.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL segn_unexpected: got %0h, expected no beat", c_s[1]);
        end else begin
          e = cq1.pop_front();
          chk("segn_result", {c_s[1], c_co[1], c_ov[1]}, e.r);
          chk("segn_latency", cyc, e.due);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_out_valid", OUT_VALID, 0);
    chk("rst_s", S, 0);
    chk("rst_cout_ovf", {Cout, OVF}, 0);
    RST = 0;
    @(posedge CLK); #1;
    chk("rst_in_ready", IN_READY, 1);
    send(10'h348, 10'd471, 0, 0, mk(10'd287, 1, 0));
    chk("latency_pre", OUT_VALID, 0);
    @(posedge CLK); #1;
    chk("latency", OUT_VALID, 1);
    send(10'd100, 10'd200, 0, 1, mk(10'd924, 0, 0));
    send(10'd100, 10'd200, 1, 1, mk(10'd923, 0, 0));
    send(10'd300, 10'd300, 0, 0, mk(10'd600, 0, 1));
    send(10'h2D4, 10'h2D4, 0, 0, mk(10'd424, 1, 1));
    send(10'h3FF, 10'd1, 0, 0, mk(10'd0, 1, 0));
    send(10'd5, 10'd7, 1, 0, mk(10'd13, 0, 0));
    send(10'd200, 10'd100, 0, 1, mk(10'd100, 1, 0));
    send(10'd256, 10'h2D4, 0, 1, mk(10'd556, 0, 1));
`ifdef PIPELINED_ADDER_SATURATE_EN
    SAT = 1;
    send(10'd300, 10'd300, 0, 0, mk(10'h1FF, 0, 1));
    send(10'h2D4, 10'h2D4, 0, 0, mk(10'h200, 1, 1));
    send(10'd5, 10'd7, 0, 0, mk(10'd12, 0, 0));
    SAT = 0;
`endif
    fork
      for (int i = 0; i < 8; i++) send(N'(i), N'(10 * i), 0, 0, mk(N'(11 * i), 0, 0));
      begin
        repeat (4) @(posedge CLK);
        #1 OUT_READY = 0;
        repeat (3) @(posedge CLK);
        #1 OUT_READY = 1;
      end
    join
    for (int n = 0; n < 50 && q.size() != 0; n++) @(posedge CLK);
    #1;
    chk("stream_drain", q.size(), 0);
    OUT_READY = 0;
    send(10'd1, 10'd2, 0, 0, mk(10'd3, 0, 0));
    send(10'd3, 10'd4, 0, 0, mk(10'd7, 0, 0));
    chk("pre_rst_valid", OUT_VALID, 1);
    RST = 1;
    @(posedge CLK); #1;
    RST = 0;
    chk("midrst_out_valid", OUT_VALID, 0);
    chk("midrst_s", S, 0);
    chk("midrst_cout_ovf", {Cout, OVF}, 0);
    chk("midrst_in_ready", IN_READY, 1);
    OUT_READY = 1;
    send(10'h155, 10'h0AB, 1, 0, mk(10'h201, 0, 1));
    csend(10'h3FF, 10'd1, 0, 0, mk(10'd0, 1, 0));
    csend(10'h348, 10'd471, 0, 0, mk(10'd287, 1, 0));
    csend(10'd100, 10'd200, 0, 1, mk(10'd924, 0, 0));
    repeat (N + 4) @(posedge CLK);
    #1;
    chk("main_drain", q.size(), 0);
    chk("seg3_drain", cq0.size(), 0);
    chk("segn_drain", cq1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined successor to the combinational ArithmeticOperator adder; adds or subtracts two OPERAND_BIT-wide operands.
- The carry chain is split into SEGMENTS register-separated slices, giving one result per cycle at a higher clock rate.
- Uses a valid/ready handshake with full-pipeline stall, so it can sit between TPU accumulation stages that may back-pressure.

Parameters:
- OPERAND_BIT, 10, operand/result width in bits (>=2).
- SEGMENTS, 2, number of carry slices = pipeline latency in cycles (1..OPERAND_BIT).

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  synchronous, active-high reset.
- IN_VALID  input  1  operand beat valid.
- IN_READY  output  1  block accepts a beat this cycle.
- A  input  OPERAND_BIT  operand A (two's complement or unsigned).
- B  input  OPERAND_BIT  operand B.
- Cin  input  1  carry-in (add) / borrow-in (sub).
- SUB  input  1  0: A+B+Cin; 1: A-B-Cin.
- OUT_VALID  output  1  result valid.
- OUT_READY  input  1  downstream accepts result.
- S  output  OPERAND_BIT  sum/difference, modulo 2^OPERAND_BIT.
- Cout  output  1  unsigned carry-out of MSB (for SUB: 1 = no borrow).
- OVF  output  1  signed overflow flag.

Behaviour:
- Segment width: SEG_W = ceil(OPERAND_BIT/SEGMENTS). The last segment takes the remainder bits.
- Effective operands: B_eff = SUB ? ~B : B; c0 = SUB ? ~Cin : Cin.
- Stage k (0-based) adds segment k of A and B_eff plus the carry registered from stage k-1 (c0 for stage 0).
- Upper operand segments are delayed by k registers and lower result segments by (SEGMENTS-1-k) registers, so all segments of one beat emerge together.
- Advance enable: en = !OUT_VALID || OUT_READY. IN_READY = en (combinational).
- A beat is accepted when IN_VALID && IN_READY. Every stage register, including per-stage valid bits, updates only when en=1.
- Latency: exactly SEGMENTS cycles from acceptance to OUT_VALID with no stall. Throughput: 1 beat/cycle while OUT_READY=1.
- Stall: while OUT_VALID=1 && OUT_READY=0, S/Cout/OVF/OUT_VALID hold stable, IN_READY=0, and no internal state changes.
- Bubbles: IN_VALID=0 beats propagate as valid=0. Data registers may update, but OUT_VALID=0.
- Output handshake: a result is consumed on OUT_VALID && OUT_READY. A new accepted beat may enter in the same cycle.
- Cout: carry out of the MSB of the full-width sum A + B_eff + c0.
- OVF: (A[MSB] == B_eff[MSB]) && (S_raw[MSB] != A[MSB]), where S_raw is the unsaturated sum.
- Reset (RST=1 at a rising edge, any time, including mid-stall):
  - All valid bits clear.
  - OUT_VALID=0, S=0, Cout=0, OVF=0.
  - In-flight beats are discarded.
  - IN_READY=1 in the cycle after reset is released.
- SEGMENTS=1: a single registered adder with latency 1.

Optional Feature:
- Macro: PIPELINED_ADDER_SATURATE_EN.
- Defined: a SAT input port (1 bit, beat-aligned with A/B, delayed alongside them) is added.
  - When SAT=1 and OVF=1, S is clamped to the signed extreme: 0 1...1 if A[MSB]=0, 1 0...0 if A[MSB]=1.
  - OVF still reports 1 and Cout is unchanged.
  - The clamp is applied in the final stage; latency is unchanged.
- Undefined: no SAT port; S is always the wrapped result.

Test Plan:
- OPERAND_BIT=10, SEGMENTS=2: A=-184 (0x348), B=471, Cin=0, SUB=0 -> after 2 cycles OUT_VALID=1, S=287, Cout=1, OVF=0.
- Subtract: A=100, B=200, Cin=0, SUB=1 -> S=924 (-100), Cout=0, OVF=0. Same operands with Cin=1 -> S=923.
- Overflow: A=300, B=300, SUB=0 -> S=600 (0x258), OVF=1. With SATURATE_EN and SAT=1 -> S=0x1FF, OVF=1. A=-300, B=-300, SAT=1 -> S=0x200, OVF=1.
- Throughput/stall: 8 back-to-back beats (A=i, B=10*i) with OUT_READY=1 -> 8 consecutive OUT_VALID beats in order, S=11*i. Hold OUT_READY=0 for 3 cycles mid-stream -> IN_READY=0, outputs frozen, no beat lost or duplicated.
- Reset mid-operation: 2 beats in flight, assert RST for 1 cycle -> next cycle OUT_VALID=0, S=0, Cout=0, OVF=0, IN_READY=1. A new beat afterwards returns its correct result after SEGMENTS cycles.
- Segment corners: SEGMENTS=3 and SEGMENTS=OPERAND_BIT with A=0x3FF, B=1, Cin=0 -> S=0, Cout=1, OVF=0; carry ripples through every slice at latency SEGMENTS.
